// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings and the
// pattern-history-table control states.
package bp_pkg;

  typedef enum logic [1:0] {
    STRONGLY_NOT = 2'd0,
    WEAKLY_NOT   = 2'd1,
    WEAKLY_YES   = 2'd2,
    STRONGLY_YES = 2'd3
  } counter_t;

  localparam counter_t COUNTER_RESET = WEAKLY_NOT;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bht_state_t;

endpackage

// File: rtl/branch_history_table_two_bits_fsm.sv
// TWO_BITS_FSM: next value of a 2-bit saturating branch counter given the
// resolved outcome.
module two_bits_fsm
  import bp_pkg::*;
(
  input  counter_t state,
  input  logic     taken,
  output counter_t next_state
);

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      STRONGLY_NOT: next_state = taken ? WEAKLY_NOT   : STRONGLY_NOT;
      WEAKLY_NOT:   next_state = taken ? WEAKLY_YES   : STRONGLY_NOT;
      WEAKLY_YES:   next_state = taken ? STRONGLY_YES : WEAKLY_NOT;
      STRONGLY_YES: next_state = taken ? STRONGLY_YES : WEAKLY_YES;
    endcase
  end

endmodule

// File: rtl/branch_history_table.sv
// Pattern history table of 2-bit counters with optional gshare indexing,
// a sequenced table clear and a saturating misprediction counter.
module branch_history_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter bit USE_GSHARE = 1'b1,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pred_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_pred_taken,
  input  logic                  clear,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   mispredict_count
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  bht_state_t            state_q, state_d;
  counter_t              table_q [DEPTH];
  counter_t              upd_next;
  logic [INDEX_BITS-1:0] ptr_q;
  logic [INDEX_BITS-1:0] ghr_q;
  logic                  upd_fire;
  logic                  sweep_done;
  logic                  unused_pc;

  assign unused_pc  = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0]};
  assign pred_index = pred_pc[INDEX_BITS+1:2] ^ ghr_q;
  assign upd_fire   = (state_q == IDLE) && upd_valid;
  assign sweep_done = (state_q == CLEAR) && (ptr_q == '1);

  two_bits_fsm u_two_bits_fsm (
    .state      (table_q[upd_index]),
    .taken      (upd_taken),
    .next_state (upd_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (clear)      state_d = CLEAR;
      CLEAR: if (sweep_done) state_d = IDLE;
    endcase
  end

  // Outputs: the table is not trusted while being swept
  always_comb begin
    busy       = (state_q == CLEAR);
    pred_taken = !busy && table_q[pred_index][1];
  end

  // Table: update port in IDLE, sequential reinitialisation in CLEAR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is a register array, so it can and must be reset like any other flop.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= COUNTER_RESET;
    end else if (state_q == CLEAR) begin
      table_q[ptr_q] <= COUNTER_RESET;
    end else if (upd_fire) begin
      table_q[upd_index] <= upd_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q            <= '0;
      mispredict_count <= '0;
    end else if (state_q == CLEAR) begin
      ptr_q <= ptr_q + INDEX_BITS'(1);
    end else if (clear) begin
      ptr_q            <= '0;
      mispredict_count <= '0;
    end else if (upd_fire && (upd_taken != upd_pred_taken) && (mispredict_count != '1)) begin
      mispredict_count <= mispredict_count + CNT_BITS'(1);
    end
  end

  generate
    if (USE_GSHARE) begin : g_ghr
      // History is non-speculative: shifted only by resolved branches.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ghr_q <= '0;
        else if (sweep_done) ghr_q <= '0;
        else if (upd_fire)   ghr_q <= {ghr_q[INDEX_BITS-2:0], upd_taken};
      end
    end else begin : g_no_ghr
      assign ghr_q = '0;
    end
  endgenerate

endmodule
